fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch control stage that wraps the 16-bit PC register.
- It drives the PC's next-value input (pc_d) and clock enable (pc_ce), and reads back the PC's registered output (pc_q).
- It fetches from instruction memory over a req/ready handshake and loads the IF/ID pipeline register consumed by decode.
- It handles stalls from the hazard unit and branch/jump redirects with flush.

Parameters:
PC_W, 16, PC and instruction-address width (word addressed)
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, first fetch address after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_q  in  PC_W  current PC (PC register output)
pc_d  out  PC_W  next PC (to PC register input)
pc_ce  out  1  PC load enable (to PC register ce)
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address
imem_ready  in  1  memory response valid for current request
imem_data  in  INSTR_W  fetched instruction
stall  in  1  decode cannot accept; hold PC and IF/ID
redirect  in  1  branch/jump taken; flush
redirect_pc  in  PC_W  redirect target
ifid_valid  out  1  IF/ID holds a valid instruction
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc  out  PC_W  address of ifid_instr
ifid_pc_plus1  out  PC_W  ifid_pc+1

Behaviour:
- Reset (rst_n=0, async):
  - state=BOOT; ifid_valid/instr/pc/pc_plus1=0; skid empty; addr_r=0.
  - While in reset: pc_ce=1, pc_d=RESET_PC, imem_req=0.
- BOOT:
  - pc_ce=1, pc_d=RESET_PC, imem_req=0; next state FETCH.
  - redirect and stall are ignored.
- FETCH:
  - imem_req=1, imem_addr=pc_q, addr_r<=pc_q every cycle.
  - Request is held until imem_ready; it is never withdrawn.
  - imem_ready=1, no stall, no redirect: ifid_instr<=imem_data, ifid_pc<=pc_q, ifid_pc_plus1<=pc_q+1, ifid_valid<=1; pc_ce=1, pc_d=pc_q+1; stay FETCH.
  - imem_ready=1, stall=1: skid<=(imem_data, pc_q); IF/ID unchanged; pc_ce=0; go HOLD.
  - imem_ready=0, stall=0: ifid_valid<=0 (bubble); pc_ce=0.
  - imem_ready=0, stall=1: IF/ID unchanged.
- HOLD:
  - imem_req=0, pc_ce=0, IF/ID unchanged while stall=1.
  - stall=0: IF/ID<=skid (valid=1); pc_ce=1, pc_d=pc_q+1; go FETCH.
- DRAIN (request outstanding at redirect):
  - imem_req=1, imem_addr=addr_r.
  - On imem_ready: response discarded, go FETCH.
  - ifid_valid held 0.
- Redirect (priority over stall and all fetch actions, all states except BOOT):
  - pc_ce=1, pc_d=redirect_pc; ifid_valid<=0; skid discarded.
  - FETCH with imem_ready=1: response dropped, stay FETCH.
  - FETCH with imem_ready=0: go DRAIN.
  - HOLD: go FETCH.
  - DRAIN: stay DRAIN; the latest target wins.
- Arithmetic: pc+1 is modulo 2^PC_W; 16'hFFFF -> 16'h0000, no carry out.
- Throughput and latency:
  - With imem_ready tied 1: one instruction per cycle.
  - Instruction at pc_q appears on IF/ID at the edge where imem_ready is sampled; it is visible the following cycle.
- pc_d/pc_ce/imem_req/imem_addr are combinational from state and inputs. IF/ID and skid are registered.
- Reset mid-request: the outstanding memory response is not tracked; memory is reset together.

Test Plan:
- Reset then imem_ready=1, imem_data=pc-derived pattern -> PC sequence 0,1,2,3; ifid_pc 0,1,2 on successive cycles, ifid_valid=1 from 2nd cycle after BOOT, ifid_pc_plus1=ifid_pc+1.
- Stall for 3 cycles while PC=5 and ready=1 -> IF/ID holds instr@4; skid holds instr@5; pc_q stays 5; after release ifid_pc=5, then 6, with no instruction lost or duplicated.
- Redirect to 16'h0040 with ready=1 at PC=8 -> next cycle ifid_valid=0, pc_q=0x40; following fetch ifid_pc=0x40.
- Redirect to 0x20 while ready=0 (2-cycle wait memory) -> DRAIN; imem_addr stays old PC until ready; response discarded; next fetch address 0x20.
- Redirect and stall asserted together in HOLD -> redirect wins; skid dropped; ifid_valid=0; fetch resumes at redirect_pc.
- RESET_PC=16'hFFFE with ready=1 -> fetch addresses FFFE, FFFF, 0000; ifid_pc_plus1 for FFFF equals 0000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage holds imem_req/imem_addr stable until imem_ready is seen.
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch control: steers the external PC register, issues imem
// requests and loads IF/ID, with a one-entry skid for stalls and redirect flush.
module fetch_stage #(
  parameter int unsigned    PC_W     = 16,
  parameter int unsigned    INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_q,
  output logic [PC_W-1:0]    pc_d,
  output logic               pc_ce,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus1
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [PC_W-1:0]    addr_r, addr_n;
  logic               skid_valid, skid_valid_n;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n;
  logic [PC_W-1:0]    skid_pc, skid_pc_n;
  logic               valid_n;
  logic [INSTR_W-1:0] instr_n;
  logic [PC_W-1:0]    ifid_pc_n, ifid_pc_plus1_n;
  logic [PC_W-1:0]    pc_plus1, skid_pc_plus1;

  assign pc_plus1      = PC_W'(pc_q + PC_W'(1));
  assign skid_pc_plus1 = PC_W'(skid_pc + PC_W'(1));

  // State, IF/ID, skid and outstanding-address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      addr_r        <= '0;
      skid_valid    <= 1'b0;
      skid_instr    <= '0;
      skid_pc       <= '0;
      ifid_valid    <= 1'b0;
      ifid_instr    <= '0;
      ifid_pc       <= '0;
      ifid_pc_plus1 <= '0;
    end else begin
      state         <= state_n;
      addr_r        <= addr_n;
      skid_valid    <= skid_valid_n;
      skid_instr    <= skid_instr_n;
      skid_pc       <= skid_pc_n;
      ifid_valid    <= valid_n;
      ifid_instr    <= instr_n;
      ifid_pc       <= ifid_pc_n;
      ifid_pc_plus1 <= ifid_pc_plus1_n;
    end
  end

  // Next state, PC steering, memory request and IF/ID/skid next values
  always_comb begin
    state_n         = state;
    pc_ce           = 1'b0;
    pc_d            = pc_q;
    imem.imem_req   = 1'b0;
    imem.imem_addr  = addr_r;
    addr_n          = addr_r;
    skid_valid_n    = skid_valid;
    skid_instr_n    = skid_instr;
    skid_pc_n       = skid_pc;
    valid_n         = ifid_valid;
    instr_n         = ifid_instr;
    ifid_pc_n       = ifid_pc;
    ifid_pc_plus1_n = ifid_pc_plus1;

    case (state)
      BOOT: begin
        pc_ce   = 1'b1;
        pc_d    = RESET_PC;
        state_n = FETCH;
      end

      FETCH: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_q;
        addr_n         = pc_q;
        if (redirect) begin
          // A pending (not yet ready) request must still be drained
          pc_ce        = 1'b1;
          pc_d         = redirect_pc;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
          state_n      = imem.imem_ready ? FETCH : DRAIN;
        end else if (imem.imem_ready && !stall) begin
          valid_n         = 1'b1;
          instr_n         = imem.imem_data;
          ifid_pc_n       = pc_q;
          ifid_pc_plus1_n = pc_plus1;
          pc_ce           = 1'b1;
          pc_d            = pc_plus1;
        end else if (imem.imem_ready) begin
          skid_valid_n = 1'b1;
          skid_instr_n = imem.imem_data;
          skid_pc_n    = pc_q;
          state_n      = HOLD;
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_ce        = 1'b1;
          pc_d         = redirect_pc;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
          state_n      = FETCH;
        end else if (!stall) begin
          valid_n         = skid_valid;
          instr_n         = skid_instr;
          ifid_pc_n       = skid_pc;
          ifid_pc_plus1_n = skid_pc_plus1;
          skid_valid_n    = 1'b0;
          pc_ce           = 1'b1;
          pc_d            = pc_plus1;
          state_n         = FETCH;
        end
      end

      DRAIN: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = addr_r;
        valid_n        = 1'b0;
        if (redirect) begin
          pc_ce = 1'b1;
          pc_d  = redirect_pc;
        end else if (imem.imem_ready) begin
          state_n = FETCH;
        end
      end

      default: state_n = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a PC-register/memory model feeds two
// instances (RESET_PC 0 and FFFE); decode consumption is checked against a queue.
module tb_fetch_stage;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcp1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] pc_q, pc_d, redirect_pc;
  logic        pc_ce, stall, redirect, mon_en;
  logic        ifid_valid;
  logic [15:0] ifid_instr, ifid_pc, ifid_pc_plus1;
  int unsigned lat, wcnt;

  logic [15:0] w_pc_q, w_pc_d;
  logic        w_pc_ce, w_valid;
  logic [15:0] w_instr, w_pc, w_pcp1;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  exp_t q_w[$];

  fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
  fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus_w ();

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_q(pc_q), .pc_d(pc_d), .pc_ce(pc_ce),
    .imem(bus), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1)
  );

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc_q(w_pc_q), .pc_d(w_pc_d), .pc_ce(w_pc_ce),
    .imem(bus_w), .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
    .ifid_valid(w_valid), .ifid_instr(w_instr), .ifid_pc(w_pc),
    .ifid_pc_plus1(w_pcp1)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // PC registers outside the DUTs
  always_ff @(posedge clk) if (pc_ce) pc_q <= pc_d;
  always_ff @(posedge clk) if (w_pc_ce) w_pc_q <= w_pc_d;

  // Memory with programmable wait states; data depends only on address
  assign bus.imem_ready   = bus.imem_req && (wcnt == lat);
  assign bus.imem_data    = mem_fn(bus.imem_addr);
  assign bus_w.imem_ready = bus_w.imem_req;
  assign bus_w.imem_data  = mem_fn(bus_w.imem_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] pcp1);
    q.push_back('{pc, mem_fn(pc), pcp1});
  endtask

  task automatic push_w(input logic [15:0] pc, input logic [15:0] pcp1);
    q_w.push_back('{pc, mem_fn(pc), pcp1});
  endtask

  task automatic cyc(input logic s, input logic r, input logic [15:0] rpc, input int unsigned l);
    @(posedge clk);
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    lat         = l;
    @(negedge clk);
  endtask

  // Decode consumes IF/ID when valid, not stalled and not flushed
  always @(negedge clk) begin
    if (mon_en && rst_n && ifid_valid && !stall && !redirect) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ifid_unexpected: got pc %h, expected no instruction", ifid_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ifid_pc", 32'(ifid_pc), 32'(e.pc));
        chk("ifid_instr", 32'(ifid_instr), 32'(e.instr));
        chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(e.pcp1));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_valid && q_w.size() > 0) begin
      exp_t e;
      e = q_w.pop_front();
      chk("wrap_ifid_pc", 32'(w_pc), 32'(e.pc));
      chk("wrap_ifid_instr", 32'(w_instr), 32'(e.instr));
      chk("wrap_ifid_pc_plus1", 32'(w_pcp1), 32'(e.pcp1));
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; lat = 0; mon_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    chk("rst_ifid_pc", 32'(ifid_pc), 32'd0);
    chk("rst_ifid_pc_plus1", 32'(ifid_pc_plus1), 32'd0);
    chk("rst_pc_ce", 32'(pc_ce), 32'd1);
    chk("rst_pc_d", 32'(pc_d), 32'h0000);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_wrap_pc_d", 32'(w_pc_d), 32'hFFFE);

    // Expected decode stream, hand-derived from the directed sequence below
    push(16'h0000, 16'h0001); push(16'h0001, 16'h0002); push(16'h0002, 16'h0003);
    push(16'h0003, 16'h0004); push(16'h0004, 16'h0005); push(16'h0005, 16'h0006);
    push(16'h0006, 16'h0007); push(16'h0040, 16'h0041); push(16'h0020, 16'h0021);
    push(16'h0030, 16'h0031); push(16'h0031, 16'h0032);
    push_w(16'hFFFE, 16'hFFFF); push_w(16'hFFFF, 16'h0000); push_w(16'h0000, 16'h0001);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("boot_pc_ce", 32'(pc_ce), 32'd1);
    chk("boot_imem_req", 32'(bus.imem_req), 32'd0);

    cyc(1'b0, 1'b0, 16'h0, 0);
    chk("f0_imem_addr", 32'(bus.imem_addr), 32'h0000);
    chk("f0_ifid_valid", 32'(ifid_valid), 32'd0);
    chk("wrap_addr0", 32'(bus_w.imem_addr), 32'hFFFE);
    cyc(1'b0, 1'b0, 16'h0, 0);
    chk("f1_ifid_valid", 32'(ifid_valid), 32'd1);
    chk("wrap_addr1", 32'(bus_w.imem_addr), 32'hFFFF);
    cyc(1'b0, 1'b0, 16'h0, 0);
    chk("wrap_addr2", 32'(bus_w.imem_addr), 32'h0000);
    cyc(1'b0, 1'b0, 16'h0, 0);
    cyc(1'b0, 1'b0, 16'h0, 0);

    // Stall three cycles with PC=5
    cyc(1'b1, 1'b0, 16'h0, 0);
    chk("stall_pc_q", 32'(pc_q), 32'h0005);
    chk("stall_ifid_pc", 32'(ifid_pc), 32'h0004);
    cyc(1'b1, 1'b0, 16'h0, 0);
    chk("hold_pc_q", 32'(pc_q), 32'h0005);
    chk("hold_imem_req", 32'(bus.imem_req), 32'd0);
    chk("hold_pc_ce", 32'(pc_ce), 32'd0);
    chk("hold_ifid_pc", 32'(ifid_pc), 32'h0004);
    cyc(1'b1, 1'b0, 16'h0, 0);
    chk("hold2_pc_q", 32'(pc_q), 32'h0005);
    cyc(1'b0, 1'b0, 16'h0, 0);
    chk("release_pc_ce", 32'(pc_ce), 32'd1);
    chk("release_pc_d", 32'(pc_d), 32'h0006);
    cyc(1'b0, 1'b0, 16'h0, 0);
    cyc(1'b0, 1'b0, 16'h0, 0);

    // Redirect with memory ready at PC=8
    cyc(1'b0, 1'b1, 16'h0040, 0);
    chk("redir_pc_q", 32'(pc_q), 32'h0008);
    chk("redir_pc_d", 32'(pc_d), 32'h0040);
    cyc(1'b0, 1'b0, 16'h0, 0);
    chk("post_redir_valid", 32'(ifid_valid), 32'd0);
    chk("post_redir_pc_q", 32'(pc_q), 32'h0040);
    cyc(1'b0, 1'b0, 16'h0, 0);

    // Two-wait-state memory; redirect while request pending -> drain
    cyc(1'b0, 1'b1, 16'h0020, 2);
    chk("drain_entry_ready", 32'(bus.imem_ready), 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 2);
    chk("drain_addr0", 32'(bus.imem_addr), 32'h0042);
    chk("drain_req", 32'(bus.imem_req), 32'd1);
    chk("drain_pc_q", 32'(pc_q), 32'h0020);
    chk("drain_valid", 32'(ifid_valid), 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 2);
    chk("drain_addr1", 32'(bus.imem_addr), 32'h0042);
    chk("drain_ready", 32'(bus.imem_ready), 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 2);
    chk("post_drain_addr", 32'(bus.imem_addr), 32'h0020);
    chk("post_drain_valid", 32'(ifid_valid), 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 2);
    cyc(1'b0, 1'b0, 16'h0, 2);
    cyc(1'b0, 1'b0, 16'h0, 0);

    // Stall into HOLD, then redirect and stall together
    cyc(1'b1, 1'b0, 16'h0, 0);
    cyc(1'b1, 1'b1, 16'h0030, 0);
    chk("hold_redir_req", 32'(bus.imem_req), 32'd0);
    chk("hold_redir_pc_ce", 32'(pc_ce), 32'd1);
    chk("hold_redir_pc_d", 32'(pc_d), 32'h0030);
    cyc(1'b0, 1'b0, 16'h0, 0);
    chk("hold_redir_valid", 32'(ifid_valid), 32'd0);
    chk("hold_redir_pc_q", 32'(pc_q), 32'h0030);
    cyc(1'b0, 1'b0, 16'h0, 0);
    cyc(1'b0, 1'b0, 16'h0, 0);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    stall  = 1'b1;
    @(negedge clk);
    chk("scoreboard_left", 32'(q.size()), 32'd0);
    chk("wrap_scoreboard_left", 32'(q_w.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
